// File: rtl/ahfp_add_arbiter.sv
// Round-robin arbiter sharing one single-precision FP adder among NUM_REQ requesters.
// Latency: 1 cycle from req_valid&req_ready transfer to out_valid with the registered sum.
// Backpressure: out_valid&!out_ready freezes the output register and withholds all grants.
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   req_valid/req_ready      per-requester handshake; req_ready is a one-hot grant
//   req_dataa/req_datab      packed operands, requester i at [32*i+31:32*i]
//   out_valid/out_ready      result handshake
//   out_result/out_id        registered sum and the index of the requester that produced it
//   stat_sel/stat_count      grant counter readout, present only with AHFP_ARB_STATS_EN
//
// Optional feature macro: AHFP_ARB_STATS_EN (per-requester saturating 16-bit grant counters).

// Combinational IEEE-754 single-precision adder, round-to-nearest-even.
// Subnormals are handled on input and output; any NaN input or inf-inf yields a quiet NaN.
module ahfp_add (
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic [31:0] result
);

    logic        sa, sb;
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        a_nan, b_nan, a_inf, b_inf;
    logic        a_ge_b, eff_sub, sign_big;
    logic [7:0]  e_big, e_sml, exp_diff;
    logic [23:0] m_big, m_sml;
    logic [27:0] big_ext, sml_ext, sml_shift;
    logic        sticky_al;
    logic [27:0] sum, norm;
    logic [4:0]  lz;
    logic [9:0]  e_big10, sh10, exp_norm, exp_fin;
    logic        round_up;
    logic [24:0] mant_rnd;
    logic [22:0] frac_fin;

    always_comb begin
        sa        = dataa[31];
        sb        = datab[31];
        ea        = dataa[30:23];
        eb        = datab[30:23];
        fa        = dataa[22:0];
        fb        = datab[22:0];
        a_nan     = (ea == 8'hFF) && (fa != 23'd0);
        b_nan     = (eb == 8'hFF) && (fb != 23'd0);
        a_inf     = (ea == 8'hFF) && (fa == 23'd0);
        b_inf     = (eb == 8'hFF) && (fb == 23'd0);
        eff_sub   = sa ^ sb;
        a_ge_b    = {ea, fa} >= {eb, fb};

        // Larger magnitude goes on the "big" side so the aligned difference is never negative.
        // Subnormals use exponent 1 with no hidden bit.
        e_big     = 8'd0;
        e_sml     = 8'd0;
        m_big     = 24'd0;
        m_sml     = 24'd0;
        sign_big  = 1'b0;
        if (a_ge_b) begin
            e_big    = (ea == 8'd0) ? 8'd1 : ea;
            m_big    = {(ea != 8'd0), fa};
            e_sml    = (eb == 8'd0) ? 8'd1 : eb;
            m_sml    = {(eb != 8'd0), fb};
            sign_big = sa;
        end else begin
            e_big    = (eb == 8'd0) ? 8'd1 : eb;
            m_big    = {(eb != 8'd0), fb};
            e_sml    = (ea == 8'd0) ? 8'd1 : ea;
            m_sml    = {(ea != 8'd0), fa};
            sign_big = sb;
        end

        // 28-bit datapath: carry, 24-bit mantissa, guard, round, sticky.
        exp_diff  = e_big - e_sml;
        big_ext   = {1'b0, m_big, 3'b000};
        sml_ext   = {1'b0, m_sml, 3'b000};
        sml_shift = 28'd0;
        sticky_al = 1'b0;
        if (exp_diff >= 8'd28) begin
            sticky_al = |sml_ext;
        end else begin
            sml_shift = sml_ext >> exp_diff;
            sticky_al = |(sml_ext & ~({28{1'b1}} << exp_diff));
        end
        sml_shift[0] = sml_shift[0] | sticky_al;

        sum = eff_sub ? (big_ext - sml_shift) : (big_ext + sml_shift);

        // Highest set bit wins, so scan upward and let later hits overwrite.
        lz = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (sum[i]) begin
                lz = 5'(26 - i);
            end
        end

        e_big10  = {2'b00, e_big};
        sh10     = 10'd0;
        norm     = 28'd0;
        exp_norm = 10'd0;
        if (sum[27]) begin
            norm     = {1'b0, sum[27:2], sum[1] | sum[0]};
            exp_norm = e_big10 + 10'd1;
        end else begin
            // Left shift stops at exponent 1 so tiny results land as subnormals.
            sh10     = ({5'd0, lz} > (e_big10 - 10'd1)) ? (e_big10 - 10'd1) : {5'd0, lz};
            norm     = sum << sh10;
            exp_norm = e_big10 - sh10;
        end

        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        mant_rnd = {1'b0, norm[26:3]} + {24'd0, round_up};

        // A subnormal that rounds up into the hidden bit becomes the smallest normal (exp 1).
        exp_fin  = 10'd0;
        frac_fin = mant_rnd[22:0];
        if (mant_rnd[24]) begin
            exp_fin  = exp_norm + 10'd1;
            frac_fin = mant_rnd[23:1];
        end else if (mant_rnd[23]) begin
            exp_fin  = exp_norm;
        end

        if (exp_fin >= 10'd255) begin
            result = {sign_big, 8'hFF, 23'd0};
        end else begin
            result = {sign_big, exp_fin[7:0], frac_fin};
        end

        // Exact cancellation gives +0 unless both operands are negative zero.
        if (sum == 28'd0) begin
            result = {sa & sb, 31'd0};
        end

        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
            result = 32'h7FC0_0000;
        end else if (a_inf) begin
            result = dataa;
        end else if (b_inf) begin
            result = datab;
        end
    end

endmodule

module ahfp_add_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [32*NUM_REQ-1:0] req_dataa,
    input  logic [32*NUM_REQ-1:0] req_datab,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 out_valid,
    output logic [31:0]          out_result,
    output logic [ID_W-1:0]      out_id,
    input  logic                 out_ready
`ifdef AHFP_ARB_STATS_EN
    ,
    input  logic [ID_W-1:0]      stat_sel,
    output logic [15:0]          stat_count
`endif
);

    if ((2 ** ID_W) < NUM_REQ) begin : g_bad_cfg
        $error("ahfp_add_arbiter: 2**ID_W (%0d) < NUM_REQ (%0d)", 2 ** ID_W, NUM_REQ);
    end

    localparam logic [ID_W:0]   NUM_REQ_W = (ID_W + 1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_IDX  = ID_W'(NUM_REQ - 1);

    logic                 out_valid_q, out_valid_d;
    logic [31:0]          out_result_q, out_result_d;
    logic [ID_W-1:0]      out_id_q, out_id_d;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;

    logic [2*NUM_REQ-1:0] req_rot_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic                 gnt_found;
    logic [ID_W-1:0]      gnt_idx;
    logic [ID_W:0]        idx_sum;
    logic                 can_issue;
    logic                 issue;
    logic [31:0]          op_a, op_b;
    logic [31:0]          add_sum;

    // Rotating the request vector so rr_ptr sits at bit 0 turns the round-robin search
    // into a fixed priority scan; the winning offset is rotated back to an absolute index.
    always_comb begin
        req_rot_dbl = {req_valid, req_valid} >> rr_ptr_q;
        req_rot     = req_rot_dbl[NUM_REQ-1:0];
        gnt_found   = 1'b0;
        gnt_idx     = '0;
        idx_sum     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!gnt_found && req_rot[k]) begin
                gnt_found = 1'b1;
                idx_sum   = {1'b0, rr_ptr_q} + (ID_W + 1)'(k);
                if (idx_sum >= NUM_REQ_W) begin
                    idx_sum = idx_sum - NUM_REQ_W;
                end
                gnt_idx = idx_sum[ID_W-1:0];
            end
        end
    end

    // A grant is only offered when the output register is free or being drained this cycle.
    assign can_issue = !out_valid_q || out_ready;
    assign issue     = gnt_found && can_issue && !reset;

    always_comb begin
        req_ready = '0;
        op_a      = 32'd0;
        op_b      = 32'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (issue && (gnt_idx == ID_W'(k))) begin
                req_ready[k] = 1'b1;
                op_a         = req_dataa[32*k +: 32];
                op_b         = req_datab[32*k +: 32];
            end
        end
    end

    ahfp_add u_add (
        .dataa  (op_a),
        .datab  (op_b),
        .result (add_sum)
    );

    always_comb begin
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_id_d     = out_id_q;
        rr_ptr_d     = rr_ptr_q;
        if (issue) begin
            out_valid_d  = 1'b1;
            out_result_d = add_sum;
            out_id_d     = gnt_idx;
            rr_ptr_d     = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_result_q <= 32'd0;
            out_id_q     <= '0;
            rr_ptr_q     <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_id_q     <= out_id_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_id     = out_id_q;

`ifdef AHFP_ARB_STATS_EN
    logic [15:0] cnt_q [NUM_REQ];
    logic [15:0] cnt_d [NUM_REQ];

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            cnt_d[k] = cnt_q[k];
            if (req_ready[k] && req_valid[k] && (cnt_q[k] != 16'hFFFF)) begin
                cnt_d[k] = cnt_q[k] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_REQ; k++) begin
            if (reset) begin
                cnt_q[k] <= 16'd0;
            end else begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    // Selects beyond NUM_REQ match no counter and read as zero.
    always_comb begin
        stat_count = 16'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (stat_sel == ID_W'(k)) begin
                stat_count = cnt_q[k];
            end
        end
    end
`endif

endmodule

// File: tb/tb_ahfp_add_arbiter.sv
// Directed bench for ahfp_add_arbiter (NUM_REQ=4, ID_W=2) with immediate-assertion checks.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// Output backpressure is exercised through out_ready stalls and a mid-stream reset.
module tb_ahfp_add_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req_valid;
    logic [127:0] req_dataa;
    logic [127:0] req_datab;
    logic [3:0]   req_ready;
    logic         out_valid;
    logic [31:0]  out_result;
    logic [1:0]   out_id;
    logic         out_ready;
`ifdef AHFP_ARB_STATS_EN
    logic [1:0]   stat_sel;
    logic [15:0]  stat_count;
`endif

    int vectors   = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ahfp_add_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_dataa  (req_dataa),
        .req_datab  (req_datab),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_result (out_result),
        .out_id     (out_id),
        .out_ready  (out_ready)
`ifdef AHFP_ARB_STATS_EN
        ,
        .stat_sel   (stat_sel),
        .stat_count (stat_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
        req_dataa[32*i +: 32] = a;
        req_datab[32*i +: 32] = b;
    endtask

    // One cycle: sample at the falling edge, then advance past the next rising edge.
    task automatic cyc_chk(input string tag, input logic [3:0] rdy, input logic vld,
                           input logic [1:0] id, input logic [31:0] res);
        @(negedge clk);
        check({tag, ".req_ready"}, {28'd0, req_ready}, {28'd0, rdy});
        check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, vld});
        check({tag, ".out_id"}, {30'd0, out_id}, {30'd0, id});
        check({tag, ".out_result"}, out_result, res);
        tick();
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 4'hF;
        out_ready = 1'b1;
        req_dataa = '0;
        req_datab = '0;
`ifdef AHFP_ARB_STATS_EN
        stat_sel  = 2'd1;
`endif
        set_ops(0, 32'h3F80_0000, 32'h3F80_0000);   // 1 + 1 = 2
        set_ops(1, 32'h4000_0000, 32'h3F80_0000);   // 2 + 1 = 3
        set_ops(2, 32'h3F80_0000, 32'hBF80_0000);   // 1 - 1 = +0
        set_ops(3, 32'h4040_0000, 32'h4040_0000);   // 3 + 3 = 6

        // Reset held with every requester asking: no grants, output register cleared.
        tick();
        for (int c = 0; c < 3; c++) begin
            cyc_chk("reset_hold", 4'b0000, 1'b0, 2'd0, 32'h0);
        end
        reset = 1'b0;

        // All requesters continuously valid: back-to-back grants 0,1,2,3,0.
        cyc_chk("rr_first",  4'b0001, 1'b0, 2'd0, 32'h0);
        cyc_chk("rr_1",      4'b0010, 1'b1, 2'd0, 32'h4000_0000);
        cyc_chk("rr_2",      4'b0100, 1'b1, 2'd1, 32'h4040_0000);
        cyc_chk("rr_3",      4'b1000, 1'b1, 2'd2, 32'h0000_0000);
        cyc_chk("rr_wrap",   4'b0001, 1'b1, 2'd3, 32'h40C0_0000);

        // Stall: output held, no grant while out_ready is low.
        req_valid = 4'b0010;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            cyc_chk("stall", 4'b0000, 1'b1, 2'd0, 32'h4000_0000);
        end
        out_ready = 1'b1;
        cyc_chk("stall_release", 4'b0010, 1'b1, 2'd0, 32'h4000_0000);

        // Grant req2, then req0 and req3 contend with pointer at 3.
        req_valid = 4'b0100;
        cyc_chk("grant_r2", 4'b0100, 1'b1, 2'd1, 32'h4040_0000);
        req_valid = 4'b1001;
        set_ops(3, 32'h4000_0000, 32'h3F80_0000);
        cyc_chk("skip_to_r3", 4'b1000, 1'b1, 2'd2, 32'h0000_0000);
        cyc_chk("then_r0",    4'b0001, 1'b1, 2'd3, 32'h4040_0000);

        // Drain with no requests: out_valid drops, data and id retained, pointer idle.
        req_valid = 4'b0000;
        cyc_chk("drain",      4'b0000, 1'b1, 2'd0, 32'h4000_0000);
        cyc_chk("idle",       4'b0000, 1'b0, 2'd0, 32'h4000_0000);
        req_valid = 4'b0110;
        cyc_chk("ptr_kept",   4'b0010, 1'b0, 2'd0, 32'h4000_0000);

        // Reset while a result is pending and stalled.
        req_valid = 4'b0000;
        out_ready = 1'b0;
        cyc_chk("pre_reset",  4'b0000, 1'b1, 2'd1, 32'h4040_0000);
        reset     = 1'b1;
        req_valid = 4'hF;
        cyc_chk("mid_reset",  4'b0000, 1'b1, 2'd1, 32'h4040_0000);
        reset = 1'b0;
        cyc_chk("post_reset", 4'b0001, 1'b0, 2'd0, 32'h0);

        // Extra arithmetic: 1 - 0.5 and inf - inf.
        set_ops(1, 32'h3F80_0000, 32'hBF00_0000);
        set_ops(2, 32'h7F80_0000, 32'hFF80_0000);
        req_valid = 4'b0010;
        out_ready = 1'b1;
        cyc_chk("sub_half",   4'b0010, 1'b1, 2'd0, 32'h4000_0000);
        req_valid = 4'b0100;
        cyc_chk("inf_minus",  4'b0100, 1'b1, 2'd1, 32'h3F00_0000);
        req_valid = 4'b0000;
        cyc_chk("nan_out",    4'b0000, 1'b1, 2'd2, 32'h7FC0_0000);

`ifdef AHFP_ARB_STATS_EN
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        req_valid = 4'b0010;
        set_ops(1, 32'h3F80_0000, 32'h3F80_0000);
        for (int c = 0; c < 3; c++) begin
            tick();
        end
        req_valid = 4'b0000;
        stat_sel  = 2'd1;
        @(negedge clk);
        check("stat_r1_three", {16'd0, stat_count}, 32'd3);
        stat_sel = 2'd0;
        @(negedge clk);
        check("stat_r0_zero", {16'd0, stat_count}, 32'd0);
        tick();
        stat_sel  = 2'd1;
        req_valid = 4'b0010;
        for (int c = 0; c < 65532; c++) begin
            tick();
        end
        req_valid = 4'b0000;
        @(negedge clk);
        check("stat_full", {16'd0, stat_count}, 32'h0000_FFFF);
        tick();
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b0000;
        @(negedge clk);
        check("stat_saturate", {16'd0, stat_count}, 32'h0000_FFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
